// File: rtl/udp_vlg_rx_mp.sv
// Multi-port UDP receiver: parses the 8-byte UDP header, matches the destination port
// against a runtime table, checks length and (optionally) the checksum, then forwards payload.
// Latency: 1 cycle from input byte to output byte. No backpressure: bytes are accepted every valid cycle.
// Ports:
//   i_clk/i_rst                 clock, synchronous active-high reset
//   i_dev_ip                    local IPv4 address (pseudo-header destination)
//   i_port_tbl/i_port_en        listening port table (entry i at [16*i+:16]) and per-entry enable
//   i_rx_*                      IPv4 payload byte stream and per-datagram IPv4 attributes
//   o_udp_*                     payload byte stream, channel index and header fields
//   o_drop_cnt                  saturating count of dropped datagrams
module udp_vlg_rx_mp #(
  parameter  int N_PORTS  = 4,
  parameter  int CHSUM_EN = 1,
  parameter  int CNT_W    = 16,
  localparam int CH_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_dev_ip,
  input  logic [16*N_PORTS-1:0] i_port_tbl,
  input  logic [N_PORTS-1:0]    i_port_en,
  input  logic [7:0]            i_rx_d,
  input  logic                  i_rx_v,
  input  logic                  i_rx_sof,
  input  logic                  i_rx_eof,
  input  logic                  i_rx_err,
  input  logic [7:0]            i_rx_proto,
  input  logic [31:0]           i_rx_src_ip,
  input  logic [15:0]           i_rx_payload_len,
  output logic [7:0]            o_udp_d,
  output logic                  o_udp_v,
  output logic                  o_udp_sof,
  output logic                  o_udp_eof,
  output logic                  o_udp_err,
  output logic [CH_W-1:0]       o_udp_ch,
  output logic [15:0]           o_udp_src_port,
  output logic [15:0]           o_udp_dst_port,
  output logic [15:0]           o_udp_len,
  output logic [31:0]           o_udp_src_ip,
  output logic [CNT_W-1:0]      o_drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_hdr_cnt;     // index of the next header byte
  logic [15:0] r_src_port, r_dst_port, r_len, r_chk;
  logic [15:0] r_acc;         // ones'-complement sum of completed 16-bit words
  logic [7:0]  r_hi;          // pending high byte of an incomplete word
  logic        r_odd;         // r_hi holds a pending byte
  logic        r_first;       // next payload byte is the first one

  // Ones'-complement 16-bit add with end-around carry; the folded result cannot overflow again.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Port match: lowest enabled entry wins, hence the descending scan.
  logic            w_hit;
  logic [CH_W-1:0] w_idx;
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (i_port_en[i] && (i_port_tbl[16*i +: 16] == r_dst_port)) begin
        w_hit = 1'b1;
        w_idx = CH_W'(i);
      end
    end
  end

  // Final checksum on the eof byte: close the pending word (odd byte padded low), then add the pseudo-header.
  logic [15:0] w_acc_eof, w_final;
  always_comb begin
    w_acc_eof = r_odd ? csum_add(r_acc, {r_hi, i_rx_d}) : csum_add(r_acc, {i_rx_d, 8'h00});
    w_final   = csum_add(w_acc_eof, i_rx_src_ip[31:16]);
    w_final   = csum_add(w_final, i_rx_src_ip[15:0]);
    w_final   = csum_add(w_final, i_dev_ip[31:16]);
    w_final   = csum_add(w_final, i_dev_ip[15:0]);
    w_final   = csum_add(w_final, 16'h0011);
    w_final   = csum_add(w_final, r_len);
  end

  logic w_busy, w_start, w_start_eof, w_abort, w_hdr_byte, w_hdr_short, w_hdr_last;
  logic w_accept, w_hdr_drop, w_pay_byte, w_pay_eof, w_chk_bad, w_drop_inc;

  always_comb begin
    w_busy      = (r_state == S_HDR) || (r_state == S_PAYLOAD);
    w_start     = i_rx_v && i_rx_sof && (i_rx_proto == 8'd17) && !i_rx_err;
    // A one-byte UDP datagram can never hold a header.
    w_start_eof = w_start && i_rx_eof;
    w_abort     = w_busy && (i_rx_err || (i_rx_v && i_rx_sof));
    w_hdr_byte  = (r_state == S_HDR) && i_rx_v && !w_abort;
    w_hdr_short = w_hdr_byte && i_rx_eof && (r_hdr_cnt != 3'd7);
    w_hdr_last  = w_hdr_byte && (r_hdr_cnt == 3'd7);
    w_accept    = w_hdr_last && w_hit && (r_len > 16'd8) && (r_len == i_rx_payload_len) && !i_rx_eof;
    w_hdr_drop  = w_hdr_last && !w_accept;
    w_pay_byte  = (r_state == S_PAYLOAD) && i_rx_v && !w_abort;
    w_pay_eof   = w_pay_byte && i_rx_eof;
    w_chk_bad   = w_pay_eof && (CHSUM_EN != 0) && (r_chk != 16'h0000) && (w_final != 16'hFFFF);
    w_drop_inc  = w_abort || w_hdr_short || w_hdr_drop || w_chk_bad || w_start_eof;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start && !w_start_eof) w_state_nxt = S_HDR;
      end
      S_HDR: begin
        if (w_abort)           w_state_nxt = (w_start && !w_start_eof) ? S_HDR : S_IDLE;
        else if (w_hdr_short)  w_state_nxt = S_IDLE;
        else if (w_accept)     w_state_nxt = S_PAYLOAD;
        else if (w_hdr_drop)   w_state_nxt = i_rx_eof ? S_IDLE : S_DROP;
      end
      S_PAYLOAD: begin
        if (w_abort)           w_state_nxt = (w_start && !w_start_eof) ? S_HDR : S_IDLE;
        else if (w_pay_eof)    w_state_nxt = S_IDLE;
      end
      S_DROP: begin
        // A fresh sof restarts parsing; the dropped datagram is already counted.
        if (i_rx_v && i_rx_sof) w_state_nxt = (w_start && !w_start_eof) ? S_HDR : S_IDLE;
        else if (i_rx_err)      w_state_nxt = S_IDLE;
        else if (i_rx_v && i_rx_eof) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_hdr_cnt  <= '0;
      r_src_port <= '0;
      r_dst_port <= '0;
      r_len      <= '0;
      r_chk      <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_odd      <= 1'b0;
      r_first    <= 1'b0;
      o_udp_d        <= '0;
      o_udp_v        <= 1'b0;
      o_udp_sof      <= 1'b0;
      o_udp_eof      <= 1'b0;
      o_udp_err      <= 1'b0;
      o_udp_ch       <= '0;
      o_udp_src_port <= '0;
      o_udp_dst_port <= '0;
      o_udp_len      <= '0;
      o_udp_src_ip   <= '0;
      o_drop_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      o_udp_v   <= 1'b0;
      o_udp_sof <= 1'b0;
      o_udp_eof <= 1'b0;
      o_udp_err <= 1'b0;

      if (w_start) begin
        r_hdr_cnt         <= 3'd1;
        r_src_port[15:8]  <= i_rx_d;
        r_acc             <= '0;
        r_hi              <= i_rx_d;
        r_odd             <= 1'b1;
        r_first           <= 1'b1;
      end else if (w_hdr_byte || w_pay_byte) begin
        if (r_odd) r_acc <= csum_add(r_acc, {r_hi, i_rx_d});
        else       r_hi  <= i_rx_d;
        r_odd <= ~r_odd;
      end

      if (w_hdr_byte) begin
        r_hdr_cnt <= r_hdr_cnt + 3'd1;
        case (r_hdr_cnt)
          3'd1: r_src_port[7:0]  <= i_rx_d;
          3'd2: r_dst_port[15:8] <= i_rx_d;
          3'd3: r_dst_port[7:0]  <= i_rx_d;
          3'd4: r_len[15:8]      <= i_rx_d;
          3'd5: r_len[7:0]       <= i_rx_d;
          3'd6: r_chk[15:8]      <= i_rx_d;
          default: r_chk[7:0]    <= i_rx_d;
        endcase
      end

      if (w_accept) begin
        o_udp_ch       <= w_idx;
        o_udp_src_port <= r_src_port;
        o_udp_dst_port <= r_dst_port;
        o_udp_len      <= r_len;
        o_udp_src_ip   <= i_rx_src_ip;
      end

      if (w_pay_byte) begin
        o_udp_v   <= 1'b1;
        o_udp_d   <= i_rx_d;
        o_udp_sof <= r_first;
        o_udp_eof <= i_rx_eof;
        o_udp_err <= w_chk_bad;
        r_first   <= 1'b0;
      end

      // Aborted payload: a data-less eof/err marker tells the consumer to discard what it has.
      if (w_abort && (r_state == S_PAYLOAD)) begin
        o_udp_eof <= 1'b1;
        o_udp_err <= 1'b1;
      end

      if (w_drop_inc && (o_drop_cnt != {CNT_W{1'b1}})) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_vlg_rx_mp.sv
// Testbench for udp_vlg_rx_mp: directed datagrams drive the receiver, expected output
// events go into a scoreboard queue and a negedge monitor pops and compares them,
// including the one-cycle input-to-output latency.
module tb_udp_vlg_rx_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dev_ip;
  logic [63:0] port_tbl;
  logic [3:0]  port_en;
  logic [7:0]  rx_d;
  logic        rx_v, rx_sof, rx_eof, rx_err;
  logic [7:0]  rx_proto;
  logic [31:0] rx_src_ip;
  logic [15:0] rx_payload_len;
  logic [7:0]  udp_d;
  logic        udp_v, udp_sof, udp_eof, udp_err;
  logic [1:0]  udp_ch;
  logic [15:0] udp_src_port, udp_dst_port, udp_len;
  logic [31:0] udp_src_ip;
  logic [15:0] drop_cnt;

  udp_vlg_rx_mp #(.N_PORTS(4), .CHSUM_EN(1), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_dev_ip(dev_ip), .i_port_tbl(port_tbl), .i_port_en(port_en),
    .i_rx_d(rx_d), .i_rx_v(rx_v), .i_rx_sof(rx_sof), .i_rx_eof(rx_eof), .i_rx_err(rx_err),
    .i_rx_proto(rx_proto), .i_rx_src_ip(rx_src_ip), .i_rx_payload_len(rx_payload_len),
    .o_udp_d(udp_d), .o_udp_v(udp_v), .o_udp_sof(udp_sof), .o_udp_eof(udp_eof), .o_udp_err(udp_err),
    .o_udp_ch(udp_ch), .o_udp_src_port(udp_src_port), .o_udp_dst_port(udp_dst_port),
    .o_udp_len(udp_len), .o_udp_src_ip(udp_src_ip), .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic        err;
    logic [1:0]  ch;
    logic [15:0] len;
    int          cyc;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output beat or eof marker must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (udp_v || udp_eof)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: v=%0b d=%02h eof=%0b err=%0b, required no output", udp_v, udp_d, udp_eof, udp_err);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (udp_v !== e.v || (e.v && udp_d !== e.d) || udp_sof !== e.sof || udp_eof !== e.eof ||
            udp_err !== e.err || udp_ch !== e.ch || udp_len !== e.len || cyc != e.cyc + 1) begin
          errors++;
          $display("FAIL out_event: got v=%0b d=%02h sof=%0b eof=%0b err=%0b ch=%0d len=%0d cyc=%0d, need v=%0b d=%02h sof=%0b eof=%0b err=%0b ch=%0d len=%0d cyc=%0d",
                   udp_v, udp_d, udp_sof, udp_eof, udp_err, udp_ch, udp_len, cyc,
                   e.v, e.d, e.sof, e.eof, e.err, e.ch, e.len, e.cyc + 1);
        end
      end
    end
  end

  task automatic mk(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len, input logic [15:0] ck);
    pkt.delete();
    pkt.push_back(sp[15:8]);  pkt.push_back(sp[7:0]);
    pkt.push_back(dp[15:8]);  pkt.push_back(dp[7:0]);
    pkt.push_back(len[15:8]); pkt.push_back(len[7:0]);
    pkt.push_back(ck[15:8]);  pkt.push_back(ck[7:0]);
  endtask

  task automatic idle(input int n);
    rx_v = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; rx_d = 8'h00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Send pkt; fwd: payload expected on channel ch; bad: eof carries err; err_idx: byte with rx_err.
  task automatic send(input logic [7:0] proto, input logic [15:0] plen, input bit gap, input int err_idx,
                      input bit fwd, input bit bad, input logic [1:0] ch, input logic [15:0] len);
    int n;
    ev_t e;
    n = pkt.size();
    for (int i = 0; i < n; i++) begin
      rx_v = 1'b1; rx_d = pkt[i]; rx_sof = (i == 0); rx_eof = (i == n - 1);
      rx_err = (i == err_idx); rx_proto = proto; rx_payload_len = plen;
      if (fwd && i == err_idx) begin
        e = '{v: 1'b0, d: 8'h00, sof: 1'b0, eof: 1'b1, err: 1'b1, ch: ch, len: len, cyc: cyc};
        sb.push_back(e);
      end else if (fwd && i >= 8) begin
        e = '{v: 1'b1, d: pkt[i], sof: (i == 8), eof: (i == n - 1), err: (bad && i == n - 1), ch: ch, len: len, cyc: cyc};
        sb.push_back(e);
      end
      @(posedge clk); #1;
      if (i == err_idx) break;
      if (gap) idle(1);
    end
    idle(3);
  endtask

  task automatic chk_drop(input string name, input logic [15:0] exp);
    checks++;
    if (drop_cnt !== exp) begin
      errors++;
      $display("FAIL %s: drop_cnt=%0d, required %0d", name, drop_cnt, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dev_ip = 32'h0A000002; rx_src_ip = 32'h0A000001;
    port_tbl = {16'd80, 16'd5000, 16'd0, 16'd80};  // entries 3..0
    port_en  = 4'b1101;
    rx_proto = 8'd17; rx_payload_len = 16'd0;
    rx_v = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; rx_d = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({udp_v, udp_sof, udp_eof, udp_err} !== 4'b0 || udp_d !== 8'h00 || udp_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_out: v=%0b sof=%0b eof=%0b err=%0b d=%02h ch=%0d, required all 0", udp_v, udp_sof, udp_eof, udp_err, udp_d, udp_ch);
    end
    checks++;
    if (udp_len !== 16'd0 || udp_src_port !== 16'd0 || udp_dst_port !== 16'd0 || udp_src_ip !== 32'd0) begin
      errors++;
      $display("FAIL reset_hdr: len=%0d sp=%0d dp=%0d ip=%08h, required all 0", udp_len, udp_src_port, udp_dst_port, udp_src_ip);
    end
    chk_drop("reset_drop", 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Port 5000 on entry 2, checksum not computed
    mk(16'd1234, 16'd5000, 16'd12, 16'h0000);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    send(8'd17, 16'd12, 1'b0, -1, 1'b1, 1'b0, 2'd2, 16'd12);
    chk_drop("nochk_drop", 16'd0);
    checks++;
    if (udp_src_port !== 16'd1234 || udp_dst_port !== 16'd5000 || udp_src_ip !== 32'h0A000001) begin
      errors++;
      $display("FAIL hdr_fields: sp=%0d dp=%0d ip=%08h, required 1234 5000 0a000001", udp_src_port, udp_dst_port, udp_src_ip);
    end

    // Correct checksum 0x35DC
    mk(16'd1234, 16'd5000, 16'd12, 16'h35DC);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    send(8'd17, 16'd12, 1'b0, -1, 1'b1, 1'b0, 2'd2, 16'd12);
    chk_drop("goodchk_drop", 16'd0);

    // One payload bit flipped -> err with eof
    mk(16'd1234, 16'd5000, 16'd12, 16'h35DC);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEE);
    send(8'd17, 16'd12, 1'b0, -1, 1'b1, 1'b1, 2'd2, 16'd12);
    chk_drop("badchk_drop", 16'd1);

    // Port 7 not in table
    mk(16'd1234, 16'd7, 16'd12, 16'h0000);
    pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03); pkt.push_back(8'h04);
    send(8'd17, 16'd12, 1'b0, -1, 1'b0, 1'b0, 2'd0, 16'd12);
    chk_drop("nomatch_drop", 16'd2);

    // Port 80 in entries 0 and 3 -> lowest index
    mk(16'd4000, 16'd80, 16'd12, 16'h0000);
    pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33); pkt.push_back(8'h44);
    send(8'd17, 16'd12, 1'b0, -1, 1'b1, 1'b0, 2'd0, 16'd12);
    chk_drop("dupport_drop", 16'd2);

    // Length field 20 vs IPv4 payload length 16
    mk(16'd1234, 16'd5000, 16'd20, 16'h0000);
    for (int i = 0; i < 8; i++) pkt.push_back(8'(i));
    send(8'd17, 16'd16, 1'b0, -1, 1'b0, 1'b0, 2'd0, 16'd20);
    chk_drop("lenmis_drop", 16'd3);

    // Empty payload
    mk(16'd1234, 16'd5000, 16'd8, 16'h0000);
    send(8'd17, 16'd8, 1'b0, -1, 1'b0, 1'b0, 2'd0, 16'd8);
    chk_drop("len8_drop", 16'd4);

    // Non-UDP protocol: ignored, not counted
    mk(16'd1234, 16'd5000, 16'd12, 16'h0000);
    pkt.push_back(8'h55); pkt.push_back(8'h66); pkt.push_back(8'h77); pkt.push_back(8'h88);
    send(8'd6, 16'd12, 1'b0, -1, 1'b0, 1'b0, 2'd0, 16'd12);
    chk_drop("tcp_drop", 16'd4);

    // rx_err on payload byte 3 (datagram byte 10)
    mk(16'd1234, 16'd5000, 16'd12, 16'h0000);
    pkt.push_back(8'hA1); pkt.push_back(8'hA2); pkt.push_back(8'hA3); pkt.push_back(8'hA4);
    send(8'd17, 16'd12, 1'b0, 10, 1'b1, 1'b0, 2'd2, 16'd12);
    chk_drop("abort_drop", 16'd5);

    // Clean datagram after the abort
    mk(16'd1234, 16'd5000, 16'd12, 16'h35DC);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    send(8'd17, 16'd12, 1'b0, -1, 1'b1, 1'b0, 2'd2, 16'd12);
    chk_drop("recover_drop", 16'd5);

    // Odd 3-byte payload with gaps, checksum 0x5CBF
    mk(16'd1234, 16'd5000, 16'd11, 16'h5CBF);
    pkt.push_back(8'hAA); pkt.push_back(8'hBB); pkt.push_back(8'hCC);
    send(8'd17, 16'd11, 1'b1, -1, 1'b1, 1'b0, 2'd2, 16'd11);
    chk_drop("odd_drop", 16'd5);

    idle(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: %0d expected events never seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
